// File: rtl/sequenciador_tampa.sv
// sequenciador_tampa
//   Sequences the cube robot's lid servo. Accepts move commands from the solver
//   FSM over an iniciar/pronto handshake, drives the servo PWM controller's
//   1-bit posicao input, and waits a fixed mechanical settle time per movement
//   before reporting completion. liberado tells the gripper/rotation logic that
//   the lid is closed and idle.
//
// Ports
//   clock      in   system clock (50 MHz)
//   reset      in   synchronous active-low reset (0 = reset)
//   iniciar    in   start request, only looked at while idle (OCIOSO)
//   comando    in   [1:0] 00 close, 01 open, 10 ciclo (open, settle, close, settle), 11 invalid
//   posicao    out  registered lid position for the servo PWM controller
//   ocupado    out  high while moving (MOVENDO or RETORNANDO)
//   pronto     out  one-cycle completion pulse
//   erro       out  one-cycle pulse alongside pronto for an invalid comando
//   liberado   out  high only when idle with the lid closed
//   db_estado  out  [2:0] state code: OCIOSO=0, MOVENDO=1, RETORNANDO=2, CONCLUIDO=3
module sequenciador_tampa #(
  parameter int TEMPO_MOVIMENTO = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] comando,
  output logic       posicao,
  output logic       ocupado,
  output logic       pronto,
  output logic       erro,
  output logic       liberado,
  output logic [2:0] db_estado
);

  localparam logic [2:0] OCIOSO     = 3'd0;
  localparam logic [2:0] MOVENDO    = 3'd1;
  localparam logic [2:0] RETORNANDO = 3'd2;
  localparam logic [2:0] CONCLUIDO  = 3'd3;

  localparam int CNT_W = (TEMPO_MOVIMENTO > 2) ? $clog2(TEMPO_MOVIMENTO) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TEMPO_MOVIMENTO - 1);

  logic [2:0]       estado;
  logic [CNT_W-1:0] contador;
  logic [1:0]       cmd_lat;

  // Saturating increment: the settle counter parks at the terminal count
  // instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == TERMINAL) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado   <= OCIOSO;
      posicao  <= 1'b0;
      contador <= '0;
      cmd_lat  <= 2'b00;
    end else begin
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            cmd_lat <= comando;
            case (comando)
              2'b00, 2'b01: begin
                // Already there: report completion without a settle wait.
                if (comando[0] == posicao) begin
                  estado <= CONCLUIDO;
                end else begin
                  posicao  <= comando[0];
                  contador <= '0;
                  estado   <= MOVENDO;
                end
              end
              2'b10: begin
                // Ciclo always runs the full open settle, even if already open.
                posicao  <= 1'b1;
                contador <= '0;
                estado   <= MOVENDO;
              end
              default: estado <= CONCLUIDO;
            endcase
          end
        end
        MOVENDO: begin
          if (contador == TERMINAL) begin
            if (cmd_lat == 2'b10) begin
              posicao  <= 1'b0;
              contador <= '0;
              estado   <= RETORNANDO;
            end else begin
              estado <= CONCLUIDO;
            end
          end else begin
            contador <= sat_inc(contador);
          end
        end
        RETORNANDO: begin
          if (contador == TERMINAL) estado <= CONCLUIDO;
          else                      contador <= sat_inc(contador);
        end
        CONCLUIDO: estado <= OCIOSO;
        default:   estado <= OCIOSO;
      endcase
    end
  end

  // Outputs decode registered state only; nothing flows through from inputs.
  assign ocupado   = (estado == MOVENDO) || (estado == RETORNANDO);
  assign pronto    = (estado == CONCLUIDO);
  assign erro      = (estado == CONCLUIDO) && (cmd_lat == 2'b11);
  assign liberado  = (estado == OCIOSO) && !posicao;
  assign db_estado = estado;

endmodule

// File: tb/tb_sequenciador_tampa.sv
// Testbench for sequenciador_tampa with TEMPO_MOVIMENTO=4. Directed sequences
// from the test plan followed by randomized commands and occasional resets,
// all compared every cycle against a time-based behavioural model.
module tb_sequenciador_tampa;
  localparam int T = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [1:0] comando = 2'b00;
  logic       posicao, ocupado, pronto, erro, liberado;
  logic [2:0] db_estado;

  int checks = 0;
  int failures = 0;

  sequenciador_tampa #(.TEMPO_MOVIMENTO(T)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .comando(comando),
    .posicao(posicao), .ocupado(ocupado), .pronto(pronto), .erro(erro),
    .liberado(liberado), .db_estado(db_estado)
  );

  always #10 clock = ~clock;

  // Behavioural model: a job is "edges left until done" plus an optional
  // "edges left until the lid closes again" for ciclo.
  bit m_pos, m_done, m_err, m_busy, m_returned;
  int m_rem, m_ret;
  int pronto_count;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge(input bit rst_n, input bit ini, input logic [1:0] cmd);
    if (!rst_n) begin
      m_pos = 0; m_done = 0; m_err = 0; m_busy = 0; m_returned = 0;
      m_rem = 0; m_ret = -1;
    end else if (m_done) begin
      m_done = 0; m_err = 0;
    end else if (m_busy) begin
      m_rem--;
      if (m_ret > 0) begin
        m_ret--;
        if (m_ret == 0) begin m_pos = 0; m_ret = -1; m_returned = 1; end
      end
      if (m_rem == 0) begin m_busy = 0; m_done = 1; m_returned = 0; end
    end else if (ini) begin
      case (cmd)
        2'b11: begin m_done = 1; m_err = 1; end
        2'b10: begin m_pos = 1; m_busy = 1; m_rem = 2*T; m_ret = T; end
        default: begin
          if (cmd[0] == m_pos) m_done = 1;
          else begin m_pos = cmd[0]; m_busy = 1; m_rem = T; m_ret = -1; end
        end
      endcase
    end
  endtask

  task automatic compare_all();
    logic [2:0] exp_st;
    exp_st = m_done ? 3'd3 : (m_busy ? (m_returned ? 3'd2 : 3'd1) : 3'd0);
    check_val("posicao",   posicao,   m_pos);
    check_val("ocupado",   ocupado,   m_busy);
    check_val("pronto",    pronto,    m_done);
    check_val("erro",      erro,      m_err);
    check_val("liberado",  liberado,  !m_busy && !m_done && !m_pos);
    check_val("db_estado", db_estado, exp_st);
  endtask

  // Apply inputs, take one clock edge, advance model, compare 1 time unit later.
  task automatic step(input bit rst_n, input bit ini, input logic [1:0] cmd);
    reset = rst_n; iniciar = ini; comando = cmd;
    @(posedge clock);
    model_edge(rst_n, ini, cmd);
    #1;
    if (pronto) pronto_count++;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 2'b00);
  endtask

  initial begin
    int pc0;
    m_ret = -1;
    step(0, 0, 2'b00);
    step(0, 1, 2'b01);            // iniciar during reset must not matter
    idle(3);
    check_val("idle_liberado", liberado, 1'b1);

    // Single open move: pronto exactly once, T cycles after sampling.
    pc0 = pronto_count;
    step(1, 1, 2'b01);
    check_val("open_pos_now", posicao, 1'b1);
    idle(T + 2);
    check_val("open_one_pronto", pronto_count - pc0, 1);
    check_val("open_liberado", liberado, 1'b0);

    // Close, then ciclo from closed.
    step(1, 1, 2'b00); idle(T + 1);
    step(1, 1, 2'b10); idle(2*T + 2);
    check_val("ciclo_liberado", liberado, 1'b1);

    // No-op then invalid.
    step(1, 1, 2'b00); step(1, 0, 2'b00);
    step(1, 1, 2'b11);
    check_val("inv_erro", erro, 1'b1);
    idle(2);

    // Request during MOVENDO is dropped.
    pc0 = pronto_count;
    step(1, 1, 2'b01); idle(1);
    step(1, 1, 2'b00);
    idle(T + 2);
    check_val("drop_pos", posicao, 1'b1);
    check_val("drop_one_pronto", pronto_count - pc0, 1);

    // Reset during RETORNANDO, then a normal command.
    step(1, 1, 2'b00); idle(T + 1);
    step(1, 1, 2'b10); idle(T + 1);
    check_val("ret_state", db_estado, 3'd2);
    step(0, 0, 2'b00);
    check_val("rst_pos", posicao, 1'b0);
    idle(2);
    step(1, 1, 2'b01); idle(T + 1);

    // Held iniciar: new command starts right after CONCLUIDO.
    for (int i = 0; i < 4*T; i++) step(1, 1, (i < 2*T) ? 2'b00 : 2'b01);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      bit r, ini;
      r   = ($urandom_range(0, 99) != 0);
      ini = ($urandom_range(0, 2) == 0);
      step(r, ini, 2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout t=%0t got=running expected=finished", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
